// File: rtl/cc_serializer_if.sv
// Line-in / R-channel-out bundle for cc_serializer.
// The slave modport is the serializer's view; master is the view of the block that drives it.
interface cc_serializer_if #(
  parameter int ID_WIDTH = 4
) ();
  logic                line_valid_i;
  logic                line_ready_o;
  logic [ID_WIDTH-1:0] line_id_i;
  logic [5:0]          line_offset_i;
  logic [511:0]        line_data_i;
  logic [ID_WIDTH-1:0] rid_o;
  logic [63:0]         rdata_o;
  logic [1:0]          rresp_o;
  logic                rlast_o;
  logic                rvalid_o;
  logic                rready_i;

  modport slave (
    input  line_valid_i, line_id_i, line_offset_i, line_data_i, rready_i,
    output line_ready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
    output line_valid_i, line_id_i, line_offset_i, line_data_i, rready_i,
    input  line_ready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/cc_serializer.sv
// Cache-line to 8-beat R-channel serializer, critical word first.
// Define CC_SERIALIZER_PINGPONG_EN for a 2-entry line buffer (back-to-back bursts); default is 1 entry.
module cc_serializer #(
  parameter int ID_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cc_serializer_if.slave bus
);

`ifdef CC_SERIALIZER_PINGPONG_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic [2:0]   beat_q, beat_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  logic [ID_WIDTH-1:0] id_mem   [DEPTH];
  logic [2:0]          off_mem  [DEPTH];
  logic [511:0]        data_mem [DEPTH];

  logic        line_ready;
  logic        accept;
  logic        beat_done;
  logic        last_done;
  logic [2:0]  word_idx;
  logic [63:0] head_words [8];

  logic                rvalid;
  logic                rlast;
  logic [ID_WIDTH-1:0] rid;
  logic [63:0]         rdata;

  // Ready depends on registered occupancy only, never on the valid/ready inputs.
  assign line_ready = (count_q < 2'(DEPTH));
  assign accept     = bus.line_valid_i && line_ready;
  assign beat_done  = (state_q == SEND) && bus.rready_i;
  assign last_done  = beat_done && (beat_q == 3'd7);

  assign word_idx = off_mem[rd_ptr_q] + beat_q;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign head_words[gi] = data_mem[rd_ptr_q][64*gi +: 64];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      beat_q   <= 3'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: occupancy decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_mem[wr_ptr_q]   <= bus.line_id_i;
      off_mem[wr_ptr_q]  <= bus.line_offset_i[5:3];
      data_mem[wr_ptr_q] <= bus.line_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rid      = '0;
    rdata    = '0;

    if (accept) begin
      wr_ptr_d = (DEPTH == 2) ? ~wr_ptr_q : 1'b0;
    end
    if (last_done) begin
      rd_ptr_d = (DEPTH == 2) ? ~rd_ptr_q : 1'b0;
    end

    // Accept and final beat on the same edge cancel out in the count.
    case ({accept, last_done})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (beat_done) begin
      beat_d = beat_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        rvalid = 1'b1;
        rlast  = (beat_q == 3'd7);
        rid    = id_mem[rd_ptr_q];
        rdata  = head_words[word_idx];
        if (last_done && (count_d == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.line_ready_o = line_ready;
  assign bus.rvalid_o     = rvalid;
  assign bus.rlast_o      = rlast;
  assign bus.rid_o        = rid;
  assign bus.rdata_o      = rdata;
  assign bus.rresp_o      = 2'b00;

endmodule

// File: tb/tb_cc_serializer.sv
// Self-checking bench for cc_serializer: vector table, hand-written corner sequences and random traffic vs. a beat-queue model.
module tb_cc_serializer;

`ifdef CC_SERIALIZER_PINGPONG_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk;
  logic rst_n;

  cc_serializer_if #(.ID_WIDTH(4)) bus_if ();

  cc_serializer #(.ID_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  id;
    logic [5:0]  off;
    logic        stall;
    logic [31:0] order;   // nibble k = word index expected on beat k
  } vec_t;

  beat_t exp_q[$];
  int    tests;
  int    fails;

  logic        obs_accept;
  logic        obs_hs;
  logic [63:0] obs_data;
  logic [3:0]  obs_id;
  logic        obs_last;
  logic        stalled_prev;
  logic [68:0] snap_prev;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pattern_line();
    logic [511:0] d;
    for (int w = 0; w < 8; w++) d[64*w +: 64] = 64'h1111_0000_0000_0000 | 64'(w);
    return d;
  endfunction

  function automatic logic [511:0] random_line();
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
    return d;
  endfunction

  // One clock cycle: check outputs against the model mid-cycle, then advance the model on the edge.
  task automatic step();
    int lines;
    beat_t b;
    logic [3:0]   in_id;
    logic [5:0]   in_off;
    logic [511:0] in_data;
    @(negedge clk);
    lines = (exp_q.size() + 7) / 8;
    chk("line_ready", 128'(bus_if.line_ready_o), 128'(lines < DEPTH));
    chk("rvalid", 128'(bus_if.rvalid_o), 128'(lines > 0));
    if (bus_if.rvalid_o && exp_q.size() > 0) begin
      b = exp_q[0];
      chk("rdata", 128'(bus_if.rdata_o), 128'(b.data));
      chk("rid", 128'(bus_if.rid_o), 128'(b.id));
      chk("rlast", 128'(bus_if.rlast_o), 128'(b.last));
      chk("rresp", 128'(bus_if.rresp_o), 128'(2'b00));
    end
    if (stalled_prev) begin
      chk("stall_stable", 128'({bus_if.rid_o, bus_if.rlast_o, bus_if.rdata_o}), 128'(snap_prev));
    end
    obs_accept   = bus_if.line_valid_i && bus_if.line_ready_o;
    obs_hs       = bus_if.rvalid_o && bus_if.rready_i;
    obs_data     = bus_if.rdata_o;
    obs_id       = bus_if.rid_o;
    obs_last     = bus_if.rlast_o;
    stalled_prev = bus_if.rvalid_o && !bus_if.rready_i;
    snap_prev    = {bus_if.rid_o, bus_if.rlast_o, bus_if.rdata_o};
    in_id   = bus_if.line_id_i;
    in_off  = bus_if.line_offset_i;
    in_data = bus_if.line_data_i;
    @(posedge clk);
    if (obs_hs && exp_q.size() > 0) void'(exp_q.pop_front());
    if (obs_accept) begin
      for (int k = 0; k < 8; k++) begin
        int w;
        w = (int'(in_off[5:3]) + k) % 8;
        b.id   = in_id;
        b.data = in_data[64*w +: 64];
        b.last = (k == 7);
        exp_q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic drive_line(input logic [3:0] id, input logic [5:0] off, input logic [511:0] data);
    bus_if.line_valid_i  = 1'b1;
    bus_if.line_id_i     = id;
    bus_if.line_offset_i = off;
    bus_if.line_data_i   = data;
  endtask

  task automatic run_vector(input vec_t v);
    int beats;
    int cyc;
    drive_line(v.id, v.off, pattern_line());
    bus_if.rready_i = 1'b1;
    step();
    chk("vec_accept", 128'(obs_accept), 128'(1'b1));
    bus_if.line_valid_i = 1'b0;
    bus_if.line_data_i  = random_line();
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 64) begin
      bus_if.rready_i = v.stall ? (cyc % 3 == 0) : 1'b1;
      step();
      if (cyc == 0) chk("vec_first_beat_latency", 128'(bus_if.rvalid_o), 128'(1'b1));
      if (obs_hs) begin
        chk("vec_word", 128'(obs_data), 128'(64'h1111_0000_0000_0000 | 64'(v.order[4*beats +: 4])));
        chk("vec_rlast", 128'(obs_last), 128'(beats == 7));
        beats++;
      end
      cyc++;
    end
    chk("vec_beat_count", 128'(beats), 128'(8));
  endtask

  vec_t vecs[5];
  int   hs_cyc[$];
  logic [3:0] hs_id[$];

  initial begin
    int cyc;
    int bad;
    tests = 0;
    fails = 0;
    stalled_prev = 1'b0;
    snap_prev    = '0;
    obs_accept   = 1'b0;
    obs_hs       = 1'b0;
    obs_data     = '0;
    obs_id       = '0;
    obs_last     = 1'b0;
    bus_if.line_valid_i  = 1'b0;
    bus_if.line_id_i     = '0;
    bus_if.line_offset_i = '0;
    bus_if.line_data_i   = '0;
    bus_if.rready_i      = 1'b0;

    vecs[0] = '{id: 4'h1, off: 6'h00, stall: 1'b0, order: 32'h76543210};
    vecs[1] = '{id: 4'h2, off: 6'h28, stall: 1'b0, order: 32'h43210765};
    vecs[2] = '{id: 4'h7, off: 6'h38, stall: 1'b1, order: 32'h65432107};
    vecs[3] = '{id: 4'hC, off: 6'h13, stall: 1'b0, order: 32'h10765432};
    vecs[4] = '{id: 4'hF, off: 6'h0C, stall: 1'b1, order: 32'h07654321};

    // Reset state
    rst_n = 1'b0;
    #3;
    chk("reset_rvalid", 128'(bus_if.rvalid_o), 128'(1'b0));
    chk("reset_outputs", 128'({bus_if.rlast_o, bus_if.rid_o, bus_if.rresp_o, bus_if.rdata_o}), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Back-to-back lines: id 3 then id A
    drive_line(4'h3, 6'h00, random_line());
    bus_if.rready_i = 1'b1;
    bad = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      step();
      if (obs_accept) begin
        if (bus_if.line_id_i == 4'h3) drive_line(4'hA, 6'h18, random_line());
        else bus_if.line_valid_i = 1'b0;
      end
      if (obs_hs) begin
        hs_cyc.push_back(cyc);
        hs_id.push_back(obs_id);
      end
    end
    chk("b2b_beats", 128'(hs_cyc.size()), 128'(16));
    if (hs_cyc.size() == 16) begin
      for (int k = 0; k < 16; k++) if (hs_id[k] !== ((k < 8) ? 4'h3 : 4'hA)) bad++;
      chk("b2b_id_order", 128'(bad), 128'(0));
      chk("b2b_gap", 128'(hs_cyc[8] - hs_cyc[7]), 128'((DEPTH == 2) ? 1 : 2));
      if (DEPTH == 2) chk("b2b_contiguous", 128'(hs_cyc[15] - hs_cyc[0]), 128'(15));
    end

`ifdef CC_SERIALIZER_PINGPONG_EN
    // Accept on the same edge as the rlast handshake
    drive_line(4'h6, 6'h08, random_line());
    bus_if.rready_i = 1'b1;
    step();
    bus_if.line_valid_i = 1'b0;
    for (int k = 0; k < 7; k++) step();
    drive_line(4'h9, 6'h30, random_line());
    step();
    chk("same_edge_rlast", 128'(obs_hs && obs_last), 128'(1'b1));
    chk("same_edge_accept", 128'(obs_accept), 128'(1'b1));
    bus_if.line_valid_i = 1'b0;
    step();
    chk("same_edge_next_beat0", 128'({obs_hs, obs_id}), 128'({1'b1, 4'h9}));
    for (int k = 0; k < 10; k++) step();
`endif

    // Reset in the middle of a burst, with beat 4 on the bus
    drive_line(4'h5, 6'h10, random_line());
    bus_if.rready_i = 1'b1;
    step();
    bus_if.line_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_rvalid", 128'(bus_if.rvalid_o), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rvalid", 128'(bus_if.rvalid_o), 128'(1'b0));
    chk("midreset_outputs", 128'({bus_if.rlast_o, bus_if.rid_o, bus_if.rdata_o}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    stalled_prev = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bus_if.line_valid_i  = ($urandom_range(0, 2) == 0);
      bus_if.line_id_i     = 4'($urandom());
      bus_if.line_offset_i = 6'($urandom());
      bus_if.line_data_i   = random_line();
      bus_if.rready_i      = ($urandom_range(0, 3) != 0);
      step();
    end
    bus_if.line_valid_i = 1'b0;
    bus_if.rready_i     = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cc_serializer.md
CC_SERIALIZER -- requirements
Module: cc_serializer

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, giving the width of line_id_i and rid_o.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port line_valid_i, input, 1, meaning a cache line is offered.
REQ-005 The block SHALL have port line_ready_o, output, 1, meaning the block can accept a line.
REQ-006 The block SHALL have port line_id_i, input, ID_WIDTH, the AXI ID of the request.
REQ-007 The block SHALL have port line_offset_i, input, 6, the request byte offset; bits [5:3] select the first word.
REQ-008 The block SHALL have port line_data_i, input, 512, the cache line; word w occupies bits [64w+63:64w].
REQ-009 The block SHALL have INCT R-channel outputs rid_o (ID_WIDTH), rdata_o (64), rresp_o (2), rlast_o (1) and rvalid_o (1).
REQ-010 The block SHALL have input rready_i, 1, the downstream R-channel ready.

Function
REQ-011 A line SHALL be accepted on a rising edge where line_valid_i and line_ready_o are both 1; id, offset and data SHALL be captured into a line buffer entry.
REQ-012 Each accepted line SHALL produce exactly 8 beats; beat k (k = 0..7) SHALL carry word (line_offset_i[5:3] + k) mod 8, using 3-bit wrap arithmetic (critical word first).
REQ-013 rlast_o SHALL be 1 only on beat 7; rresp_o SHALL always be 2'b00; rid_o SHALL equal the captured id on every beat.
REQ-014 rvalid_o SHALL rise on the first edge after acceptance when the block is idle, giving 1 cycle of latency from accept to first beat.
REQ-015 A beat SHALL complete on an edge where rvalid_o and rready_i are both 1; the 3-bit beat counter SHALL then increment, and from 7 it SHALL return to 0 and release the buffer entry.
REQ-016 Once asserted, rvalid_o SHALL remain 1 and rid_o, rdata_o, rresp_o and rlast_o SHALL stay stable until the beat completes.
REQ-017 The state machine SHALL have two states: IDLE (no entry occupied, rvalid_o=0) and SEND (head entry streaming, rvalid_o=1).
REQ-018 IDLE SHALL go to SEND on accept; SEND SHALL go to IDLE on completion of beat 7 when no other entry is occupied, otherwise it SHALL stay in SEND with the next entry's beat 0 presented on the following cycle.
REQ-019 Lines SHALL be emitted in strict acceptance order, and beats of different lines SHALL never interleave.
REQ-020 line_ready_o SHALL be a function of registered occupancy only, with no combinational path from rready_i or line_valid_i.
REQ-021 When an accept and a final-beat completion occur on the same edge, both SHALL take effect: the occupancy count SHALL be unchanged and no data SHALL be lost.
REQ-022 While rready_i is held at 0, the block SHALL hold its state indefinitely with rdata_o unchanged.
REQ-023 line_data_i SHALL be sampled only on the accept edge, and later changes to it SHALL have no effect.

Reset
REQ-024 While rst_n is 0, rvalid_o, rlast_o, rid_o, rdata_o and rresp_o SHALL be 0, the state SHALL be IDLE, all entries SHALL be empty and the beat counter SHALL be 0.
REQ-025 line_ready_o SHALL be 1 from the first edge after rst_n deasserts.
REQ-026 Reset asserted mid-burst SHALL immediately drop rvalid_o and discard all buffered lines, and no partial burst SHALL resume after release.

Configuration
REQ-027 Macro CC_SERIALIZER_PINGPONG_EN defined: the block SHALL use a 2-entry line buffer with line_ready_o = (occupancy < 2), allowing back-to-back lines with zero idle cycles between one line's rlast beat and the next line's beat 0.
REQ-028 Macro CC_SERIALIZER_PINGPONG_EN undefined: the block SHALL use a single entry with line_ready_o = (occupancy == 0), giving a minimum of 2 cycles from the rlast handshake to the next line's beat 0.

Verification
REQ-029 Scenario: data word w = 64'h1111_0000_0000_000w, offset 6'h00, rready_i held at 1 -> beats carry words 0..7 on 8 consecutive cycles, rlast_o=1 only on word 7, first beat 1 cycle after accept.
REQ-030 Scenario: same line with offset 6'h28 -> word order 5,6,7,0,1,2,3,4, with rlast_o on word 4.
REQ-031 Scenario: rready_i toggled 1,0,0,1,... with offset 6'h38 -> rdata_o stable during stalls, exactly 8 handshakes, order 7,0..6.
REQ-032 Scenario: two lines, id 4'h3 then 4'hA, offered back-to-back with rready_i=1 -> with the macro, 16 consecutive beats with rid_o 3 then A; without the macro, a gap of at least 1 cycle and line_ready_o=0 during the first line.
REQ-033 Scenario: rst_n pulled to 0 at beat 4 -> rvalid_o=0 in the same cycle; after release, line_ready_o=1 and no stale beats appear.
REQ-034 Scenario: line_valid_i asserted on the same cycle as the rlast handshake with the macro defined -> accepted, and the next line's beat 0 appears the following cycle.
